// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default geometry for the register file and its
// neighbours (decode, write-back).
package regfile_pkg;

    // Bulk-clear sequencer states
    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Default geometry shared with decode and write-back
    localparam int RF_DEFAULT_WIDTH = 16;
    localparam int RF_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/write-back side bundle of the register file.
//
// Handshake semantics: there is no valid/ready pair. w_en, rsv_en and clr_req
// are fire-and-forget strobes sampled on the rising edge. They take effect only
// while clr_busy is low; while clr_busy is high they are dropped (never queued),
// so a producer that must not lose a write has to hold it until clr_busy is low.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_DEFAULT_WIDTH,
    parameter int DEPTH = RF_DEFAULT_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    // Read side
    logic [AW-1:0]    src0;
    logic [AW-1:0]    src1;
    logic [AW-1:0]    dest;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] dest_out;
    logic             src0_busy;
    logic             src1_busy;
    logic             dest_busy;

    // Write-back side
    logic             w_en;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_in;

    // Reservation side
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;

    // Bulk clear
    logic             clr_req;
    logic             clr_busy;

    // Sequencer state, exported for observation
    rf_state_e        state_dbg;

    modport master (
        output src0, src1, dest, w_en, w_addr, w_in, rsv_en, rsv_addr, clr_req,
        input  op0, op1, dest_out, src0_busy, src1_busy, dest_busy, clr_busy, state_dbg
    );

    modport slave (
        input  src0, src1, dest, w_en, w_addr, w_in, rsv_en, rsv_addr, clr_req,
        output op0, op1, dest_out, src0_busy, src1_busy, dest_busy, clr_busy, state_dbg
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for hazard detection.
// Optional feature macro: REGFILE_BYPASS_EN (a forwarded write hides the
// pending bit of its target unless a same-cycle reservation re-arms it).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH    = RF_DEFAULT_DEPTH,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    // reservation from decode (already gated to IDLE and a writable address)
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    // completing write-back (already gated to IDLE and a writable address)
    input  logic          wr_clr_en,
    input  logic [AW-1:0] wr_clr_addr,
    // bulk-clear sweep
    input  logic          sweep_en,
    input  logic [AW-1:0] sweep_addr,
    // busy lookups
    input  logic [AW-1:0] src0,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] dest,
    output logic          src0_busy,
    output logic          src1_busy,
    output logic          dest_busy
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Address is backed by a real register that can ever be pending
    function automatic logic readable(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Pending lookup for one read port
    function automatic logic busy_of(input logic [AW-1:0] a);
        logic b;
        b = 1'b0;
        if (readable(a)) begin
            b = pending_q[a];
`ifdef REGFILE_BYPASS_EN
            // The data is being forwarded this cycle, so the old producer is done;
            // only a reservation landing in the same cycle keeps it busy.
            if (wr_clr_en && (wr_clr_addr == a)) begin
                b = set_en && (set_addr == a);
            end
`endif
        end
        return b;
    endfunction

    // Next pending vector: clears first, reservation last so the newer producer wins
    always_comb begin
        pending_d = pending_q;
        if (sweep_en) begin
            pending_d[sweep_addr] = 1'b0;
        end
        if (wr_clr_en) begin
            pending_d[wr_clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
    end

    // Pending register, cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Busy outputs for the three read ports
    always_comb begin
        src0_busy = busy_of(src0);
        src1_busy = busy_of(src1);
        dest_busy = busy_of(dest);
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: WIDTH x DEPTH register file with write-back scoreboard and a
// sequential bulk-clear engine (one register per cycle).
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_DEFAULT_WIDTH,
    parameter int DEPTH    = RF_DEFAULT_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    rf_state_e        state_q;
    rf_state_e        state_d;
    logic [AW-1:0]    clr_cnt_q;
    logic [AW-1:0]    clr_cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             idle;
    logic             sweep;
    logic             wr_fire;
    logic             rsv_fire;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_in;

    // Register exists and is not the hard-wired zero register
    function automatic logic writable(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign idle     = (state_q == RF_IDLE);
    assign sweep    = (state_q == RF_CLEAR);
    assign w_addr   = bus.w_addr;
    assign w_in     = bus.w_in;
    assign wr_fire  = idle && bus.w_en && writable(bus.w_addr);
    assign rsv_fire = idle && bus.rsv_en && writable(bus.rsv_addr);

    // Read data for one port: stored value, or forwarded write data when enabled
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (writable(a)) begin
            v = mem_q[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_fire && (w_addr == a)) begin
                v = w_in;
            end
`endif
        end
        return v;
    endfunction

    // Clear sequencer: IDLE -> CLEAR on clr_req, one register per cycle, back after DEPTH-1
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            RF_IDLE: begin
                if (bus.clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            RF_CLEAR: begin
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = RF_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d   = RF_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Sequencer state and sweep counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RF_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next array contents: sweep zeroes one entry, write-back lands only in IDLE
    always_comb begin
        mem_d = mem_q;
        if (sweep) begin
            mem_d[clr_cnt_q] = '0;
        end
        if (wr_fire) begin
            mem_d[w_addr] = w_in;
        end
    end

    // Data array storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read ports and status
    always_comb begin
        bus.op0       = read_port(bus.src0);
        bus.op1       = read_port(bus.src1);
        bus.dest_out  = read_port(bus.dest);
        bus.clr_busy  = sweep;
        bus.state_dbg = state_q;
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (rsv_fire),
        .set_addr    (bus.rsv_addr),
        .wr_clr_en   (wr_fire),
        .wr_clr_addr (w_addr),
        .sweep_en    (sweep),
        .sweep_addr  (clr_cnt_q),
        .src0        (bus.src0),
        .src1        (bus.src1),
        .dest        (bus.dest),
        .src0_busy   (bus.src0_busy),
        .src1_busy   (bus.src1_busy),
        .dest_busy   (bus.dest_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb (WIDTH=16, DEPTH=8, ZERO_REG=1).
// Expectations adapt to REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_sb #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.src0     = '0;
        bus.src1     = '0;
        bus.dest     = '0;
        bus.w_en     = 1'b0;
        bus.w_addr   = '0;
        bus.w_in     = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every register reads 0 and is not busy on all three ports
    task automatic check_all_clear(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            bus.src0 = 3'(a);
            bus.src1 = 3'(a);
            bus.dest = 3'(a);
            #1;
            check($sformatf("%s_op0_r%0d", tag, a), 32'(bus.op0), 32'h0);
            check($sformatf("%s_op1_r%0d", tag, a), 32'(bus.op1), 32'h0);
            check($sformatf("%s_dst_r%0d", tag, a), 32'(bus.dest_out), 32'h0);
            check($sformatf("%s_b0_r%0d", tag, a), 32'(bus.src0_busy), 32'h0);
            check($sformatf("%s_b1_r%0d", tag, a), 32'(bus.src1_busy), 32'h0);
            check($sformatf("%s_bd_r%0d", tag, a), 32'(bus.dest_busy), 32'h0);
        end
    endtask

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int hi;
        logic [WIDTH-1:0] fill_val [DEPTH];

        for (int i = 0; i < DEPTH; i++) begin
            fill_val[i] = 16'(i) * 16'h1111;
        end

        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        check("rst_clr_busy", 32'(bus.clr_busy), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'(RF_IDLE));
        check_all_clear("rst");
        reset = 1'b0;
        tick();

        // Write BEEF to r3, read back
        bus.w_en = 1'b1; bus.w_addr = 3'd3; bus.w_in = 16'hBEEF; bus.src0 = 3'd3;
        #1;
        check("wr_r3_same_cycle", 32'(bus.op0), BYPASS ? 32'hBEEF : 32'h0);
        tick();
        bus.w_en = 1'b0;
        #1;
        check("wr_r3_next", 32'(bus.op0), 32'hBEEF);

        // Zero register ignores write and reservation
        bus.w_en = 1'b1; bus.w_addr = 3'd0; bus.w_in = 16'h1234;
        bus.rsv_en = 1'b1; bus.rsv_addr = 3'd0; bus.src0 = 3'd0;
        #1;
        check("r0_op0_during", 32'(bus.op0), 32'h0);
        check("r0_busy_during", 32'(bus.src0_busy), 32'h0);
        tick();
        bus.w_en = 1'b0; bus.rsv_en = 1'b0;
        #1;
        check("r0_op0_after", 32'(bus.op0), 32'h0);
        check("r0_busy_after", 32'(bus.src0_busy), 32'h0);

        // Reserve r5, then same-cycle reserve + write on r5
        bus.rsv_en = 1'b1; bus.rsv_addr = 3'd5; bus.src1 = 3'd5;
        tick();
        bus.rsv_en = 1'b0;
        #1;
        check("rsv_r5_busy", 32'(bus.src1_busy), 32'h1);
        bus.rsv_en = 1'b1; bus.rsv_addr = 3'd5;
        bus.w_en = 1'b1; bus.w_addr = 3'd5; bus.w_in = 16'h00AA;
        tick();
        bus.rsv_en = 1'b0; bus.w_en = 1'b0;
        #1;
        check("rsvwr_r5_data", 32'(bus.op1), 32'h00AA);
        check("rsvwr_r5_busy", 32'(bus.src1_busy), 32'h1);
        // A plain write-back retires the reservation
        bus.w_en = 1'b1; bus.w_addr = 3'd5; bus.w_in = 16'h00BB;
        tick();
        bus.w_en = 1'b0;
        #1;
        check("wr_r5_data", 32'(bus.op1), 32'h00BB);
        check("wr_r5_busy", 32'(bus.src1_busy), 32'h0);

        // Fill r1..r7, reserve r2, then bulk clear
        for (int i = 1; i < DEPTH; i++) begin
            bus.w_en = 1'b1; bus.w_addr = 3'(i); bus.w_in = fill_val[i];
            tick();
        end
        bus.w_en = 1'b0;
        bus.rsv_en = 1'b1; bus.rsv_addr = 3'd2;
        tick();
        bus.rsv_en = 1'b0;
        bus.src1 = 3'd7; bus.dest = 3'd2;
        #1;
        check("fill_r7", 32'(bus.op1), 32'h7777);
        check("fill_r2_busy", 32'(bus.dest_busy), 32'h1);

        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        hi = 0;
        for (int c = 0; c < 20 && bus.clr_busy; c++) begin
            hi++;
            if (c == 0) begin
                // Traffic during CLEAR must be dropped
                bus.w_en = 1'b1; bus.w_addr = 3'd4; bus.w_in = 16'hDEAD;
                bus.rsv_en = 1'b1; bus.rsv_addr = 3'd6; bus.clr_req = 1'b1;
                bus.src0 = 3'd1;
                #1;
                check("clr_c0_r1_live", 32'(bus.op0), 32'h1111);
                check("clr_c0_state", 32'(bus.state_dbg), 32'(RF_CLEAR));
            end
            if (c == 2) begin
                bus.src0 = 3'd1; bus.src1 = 3'd3;
                #1;
                check("clr_c2_r1_cleared", 32'(bus.op0), 32'h0);
                check("clr_c2_r3_intact", 32'(bus.op1), 32'h3333);
            end
            tick();
            bus.w_en = 1'b0; bus.rsv_en = 1'b0; bus.clr_req = 1'b0;
        end
        check("clr_busy_cycles", 32'(hi), 32'd8);
        check("clr_state_idle", 32'(bus.state_dbg), 32'(RF_IDLE));
        check_all_clear("post_clr");

        // First write accepted as soon as clr_busy is low
        bus.w_en = 1'b1; bus.w_addr = 3'd4; bus.w_in = 16'h4444;
        tick();
        bus.w_en = 1'b0;
        bus.src0 = 3'd4;
        #1;
        check("post_clr_wr_r4", 32'(bus.op0), 32'h4444);

        // Forwarding check on r2 (r2 reserved first so busy masking is visible)
        bus.rsv_en = 1'b1; bus.rsv_addr = 3'd2;
        tick();
        bus.rsv_en = 1'b0;
        bus.w_en = 1'b1; bus.w_addr = 3'd2; bus.w_in = 16'h5A5A; bus.src0 = 3'd2;
        #1;
        check("byp_op0_same", 32'(bus.op0), BYPASS ? 32'h5A5A : 32'h0);
        check("byp_busy_same", 32'(bus.src0_busy), BYPASS ? 32'h0 : 32'h1);
        tick();
        bus.w_en = 1'b0;
        #1;
        check("byp_op0_next", 32'(bus.op0), 32'h5A5A);
        check("byp_busy_next", 32'(bus.src0_busy), 32'h0);

        // Reset in the middle of CLEAR (counter = 3)
        bus.rsv_en = 1'b1; bus.rsv_addr = 3'd6;
        tick();
        bus.rsv_en = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tick();
        tick();
        tick();
        bus.src0 = 3'd4; bus.src1 = 3'd6;
        #1;
        check("mid_clr_busy", 32'(bus.clr_busy), 32'h1);
        check("mid_clr_r4_intact", 32'(bus.op0), 32'h4444);
        check("mid_clr_r6_busy", 32'(bus.src1_busy), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_clr_busy", 32'(bus.clr_busy), 32'h0);
        check("abort_state", 32'(bus.state_dbg), 32'(RF_IDLE));
        check_all_clear("abort");
        tick();
        reset = 1'b0;
        tick();

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
